// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared opcodes, command record and FSM states for the jk command sequencer
package jk_seq_pkg;

    localparam int JK_WIDTH = 4;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef struct packed {
        logic [1:0]          op;
        logic [JK_WIDTH-1:0] mask;
        logic [3:0]          rpt;
    } jk_cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_t;

    // Next Q of a bank of JK flip-flops given the J/K they sample.
    function automatic logic [JK_WIDTH-1:0] jk_next_q(
        input logic [JK_WIDTH-1:0] q,
        input logic [JK_WIDTH-1:0] j,
        input logic [JK_WIDTH-1:0] k
    );
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// rtl/jk_cmd_fifo.sv - count-based synchronous command FIFO, head read combinationally, no fall-through
module jk_cmd_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - queues SET/CLEAR/TOGGLE/HOLD commands and replays them as registered j/k beats
// Optional feature macro: SHADOW_CHECK_EN (compare fb_q against the shadow copy, sticky mismatch flag).
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = JK_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_mask,
    input  logic [3:0]       i_cmd_rpt,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_shadow_q,
    input  logic [WIDTH-1:0] i_fb_q,
    output logic             o_mismatch
);

    seq_state_t       r_state;
    seq_state_t       w_state_nx;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nx;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_mask_nx;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nx;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] w_j_nx;
    logic [WIDTH-1:0] w_k_nx;
    logic [WIDTH-1:0] r_shadow;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    jk_cmd_t          w_wdata;
    jk_cmd_t          w_head;

    assign w_wdata = '{op: i_cmd_op, mask: i_cmd_mask, rpt: i_cmd_rpt};

    jk_cmd_fifo #(
        .DW    ($bits(jk_cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_cmd_valid),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Popping whenever the current command ends lets back-to-back commands issue with no bubble.
    always_comb begin
        w_state_nx = r_state;
        w_op_nx    = r_op;
        w_mask_nx  = r_mask;
        w_cnt_nx   = r_cnt;
        w_pop      = 1'b0;
        w_j_nx     = '0;
        w_k_nx     = '0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_op_nx    = w_head.op;
                    w_mask_nx  = w_head.mask;
                    w_cnt_nx   = w_head.rpt;
                    w_state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (r_cnt == 4'd0) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_op_nx   = w_head.op;
                        w_mask_nx = w_head.mask;
                        w_cnt_nx  = w_head.rpt;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        if (w_state_nx == ISSUE) begin
            case (w_op_nx)
                OP_CLEAR:  w_k_nx = w_mask_nx;
                OP_SET:    w_j_nx = w_mask_nx;
                OP_TOGGLE: begin
                    w_j_nx = w_mask_nx;
                    w_k_nx = w_mask_nx;
                end
                OP_HOLD:   w_j_nx = '0;
                default:   w_j_nx = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_op     <= OP_HOLD;
            r_mask   <= '0;
            r_cnt    <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_shadow <= '0;
        end else begin
            r_op     <= w_op_nx;
            r_mask   <= w_mask_nx;
            r_cnt    <= w_cnt_nx;
            r_j      <= w_j_nx;
            r_k      <= w_k_nx;
            r_shadow <= jk_next_q(r_shadow, r_j, r_k);
        end
    end

`ifdef SHADOW_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= r_mismatch | (i_fb_q != r_shadow);
        end
    end

    assign o_mismatch = r_mismatch;
`else
    logic w_unused_fb;

    assign w_unused_fb = ^i_fb_q;
    assign o_mismatch  = 1'b0;
`endif

    assign o_cmd_ready = !w_full;
    assign o_busy      = (r_state == ISSUE) || !w_empty;
    assign o_j         = r_j;
    assign o_k         = r_k;
    assign o_shadow_q  = r_shadow;

endmodule
